register_file_mp: RTL
=====================

# register_file_mp

Parametrised multi-port register file with a per-register busy scoreboard, optional write-to-read bypass and a hardwired zero register. It sits in the decode stage of the pipelined datapath. Multi-issue and hazard logic read operands and producer status from it in the same cycle.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, register count (power of two, ≥4); SEL_W = $clog2(NREGS) is a localparam
- NREAD, 2, number of read ports
- NWRITE, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to readers; 0 = readers see pre-write value
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- rsel  in  NREAD*SEL_W  packed read selects, port i at [i*SEL_W +: SEL_W]
- rdat  out  NREAD*DATA_W  packed read data, combinational
- rbusy  out  NREAD  port i: selected register has an outstanding producer
- WEN  in  NWRITE  per-port write enable
- wsel  in  NWRITE*SEL_W  packed write selects
- wdat  in  NWRITE*DATA_W  packed write data
- rsv_en  in  1  reserve request: mark rsv_sel busy
- rsv_sel  in  SEL_W  register to reserve
- busy_cnt  out  SEL_W+1  number of registers currently busy

## Operation
- Storage: NREGS x DATA_W flops plus NREGS busy bits. Register 0 reads 0 and is never busy. Writes and reserves to 0 are ignored.
- Write: on an edge with WEN[j]=1 and wsel[j]≠0, reg[wsel[j]] <= wdat[j] and busy[wsel[j]] <= 0.
- Write collision: several enabled ports with the same wsel. The highest-index port wins for data. Busy is still cleared.
- Reserve: rsv_en=1 and rsv_sel≠0 sets busy[rsv_sel] <= 1.
- Reserve and write to the same register in the same cycle: the reserve wins. Busy ends at 1 and data is updated. This models a new producer issued while an old one retires.
- Read, BYPASS=1:
  - rdat[i] = wdat of the highest-index enabled write port whose wsel equals rsel[i], otherwise reg[rsel[i]].
  - rbusy[i] = busy[rsel[i]] AND NOT (some enabled write hits rsel[i]).
- Read, BYPASS=0: rdat[i] = reg[rsel[i]] and rbusy[i] = busy[rsel[i]]. Same-cycle writes are ignored.
- rsel[i]=0 always gives rdat 0 and rbusy 0, regardless of writes.
- busy_cnt: registered population count of the busy bits. It is updated on every edge together with those bits and ranges 0..NREGS-1.

## Timing
- Reset, checked at the edge while RST=1:
  - every register, every busy bit and busy_cnt go to 0.
  - writes and reserves presented in a reset cycle are discarded.
  - A reset mid-operation clears all pending busy state with no drain.
- Write latency: 1 edge to storage. With BYPASS=1 the read port sees the data in the same cycle (0 cycles); with BYPASS=0 it appears after 1 edge.
- Reserve latency: rbusy asserts in the cycle after the rsv_en edge. busy_cnt is valid in that same cycle.
- Reading a register that is being reserved in the same cycle returns its old busy state; the reserve does not forward.
- Outputs rdat and rbusy are combinational from rsel, WEN, wsel, wdat and the stored state. No handshake; every request is accepted each cycle.

## Test plan
- Reset: write 99 to $2, then RST=1 for one edge -> rdat for $2 = 0, busy_cnt = 0, all rbusy = 0.
- Zero register: WEN[0]=1, wsel=0, wdat=99, rsv_en=1, rsv_sel=0 -> rdat for $0 = 0 before and after the edge, rbusy 0, busy_cnt 0.
- Bypass: BYPASS=1, write 12345 to $17 while rsel[1]=17 -> rdat[1]=12345 in the same cycle. With BYPASS=0 -> old value, then 12345 after the edge.
- Write collision: port0 writes 4721 to $5 and port1 writes 25119 to $5 in the same cycle -> $5 reads 25119 after the edge.
- Scoreboard:
  - reserve $3 -> the next cycle shows rbusy=1 and busy_cnt=1.
  - then write 7 to $3 -> with BYPASS=1, rbusy=0 in the write cycle; after the edge, busy_cnt=0 and $3 reads 7.
- Reserve and write same cycle: $8 is busy, then rsv_sel=8 and a write of 1 to $8 on the same edge -> $8 reads 1, rbusy stays 1, busy_cnt unchanged.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file with a per-register busy scoreboard, an optional
// write-to-read bypass and a hardwired zero register.
module register_file_mp #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 2,
    parameter  bit BYPASS = 1'b1,
    localparam int SEL_W  = $clog2(NREGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREAD*SEL_W-1:0]   rsel,
    output logic [NREAD*DATA_W-1:0]  rdat,
    output logic [NREAD-1:0]         rbusy,
    input  logic [NWRITE-1:0]        WEN,
    input  logic [NWRITE*SEL_W-1:0]  wsel,
    input  logic [NWRITE*DATA_W-1:0] wdat,
    input  logic                     rsv_en,
    input  logic [SEL_W-1:0]         rsv_sel,
    output logic [SEL_W:0]           busy_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;

    function automatic logic [SEL_W:0] popcount(input logic [NREGS-1:0] v);
        logic [SEL_W:0] cnt;
        cnt = '0;
        for (int unsigned k = 0; k < NREGS; k++) begin
            cnt = cnt + {{SEL_W{1'b0}}, v[k]};
        end
        return cnt;
    endfunction

    // Retiring writes clear busy first so a same-cycle reserve ends set.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (WEN[j] && (wsel[j*SEL_W +: SEL_W] != '0)) begin
                busy_nxt[wsel[j*SEL_W +: SEL_W]] = 1'b0;
            end
        end
        if (rsv_en && (rsv_sel != '0)) begin
            busy_nxt[rsv_sel] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Later ports' non-blocking writes override earlier ones on collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int unsigned j = 0; j < NWRITE; j++) begin
                if (WEN[j] && (wsel[j*SEL_W +: SEL_W] != '0)) begin
                    regs[wsel[j*SEL_W +: SEL_W]] <= wdat[j*DATA_W +: DATA_W];
                end
            end
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

    logic [SEL_W-1:0]  s;
    logic [DATA_W-1:0] d;
    logic              b;
    logic              hit;

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        s     = '0;
        d     = '0;
        b     = 1'b0;
        hit   = 1'b0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            s   = rsel[i*SEL_W +: SEL_W];
            d   = regs[s];
            b   = busy[s];
            hit = 1'b0;
            if (BYPASS) begin
                for (int unsigned j = 0; j < NWRITE; j++) begin
                    if (WEN[j] && (wsel[j*SEL_W +: SEL_W] == s)) begin
                        d   = wdat[j*DATA_W +: DATA_W];
                        hit = 1'b1;
                    end
                end
            end
            if (s == '0) begin
                d = '0;
                b = 1'b0;
            end
            rdat[i*DATA_W +: DATA_W] = d;
            rbusy[i]                 = b & ~hit;
        end
    end

endmodule
